// File: rtl/dsu_uart_pkg.sv
// Shared constants for the DSU debug UART: register bit positions,
// serial engine state encodings and frame geometry.
package dsu_uart_pkg;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_IE_TX    = 2;
    localparam int CTRL_IE_RX    = 3;
    localparam int CTRL_IE_ERR   = 4;
    localparam int CTRL_ERR_CLR  = 5;
    localparam int CTRL_TX_FLUSH = 6;
    localparam int CTRL_RX_FLUSH = 7;

    localparam logic [7:0] CTRL_RESET = 8'h03;

    localparam int STA_TX_BUSY    = 0;
    localparam int STA_RX_BUSY    = 1;
    localparam int STA_TX_FULL    = 2;
    localparam int STA_TX_EMPTY   = 3;
    localparam int STA_RX_FULL    = 4;
    localparam int STA_RX_AVAIL   = 5;
    localparam int STA_RX_OVERRUN = 6;
    localparam int STA_FRAME_ERR  = 7;

    localparam int FRAME_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // RX_WAIT_HIGH parks the receiver after a bad stop bit until the line recovers.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/dsu_uart_sfifo.sv
// Byte-wide synchronous FIFO with flush, occupancy count and a
// combinational head that reads as zero when empty.
module dsu_uart_sfifo #(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [7:0]    data_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LEVEL);
    assign level_o = level_q;
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dsu_uart_fifo.sv
// DSU debug UART: SPR control/status registers, TX/RX FIFOs, the serial
// bit engines, sticky error flags and a registered interrupt.
module dsu_uart_fifo #(
    parameter int  BAUD_DIV   = 16,
    parameter int  FIFO_DEPTH = 8,
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rxd,
    output logic               txd,
    input  logic [7:0]         spr_dat_i,
    input  logic               reg_ctrl_we,
    input  logic               reg_txdata_we,
    input  logic               reg_rxdata_re,
    output logic [7:0]         reg_ctrl,
    output logic [7:0]         reg_sta,
    output logic [7:0]         reg_rxdata,
    output logic [FIFO_AW:0]   rx_level,
    output logic [FIFO_AW:0]   tx_level,
    output logic               irq
);

    import dsu_uart_pkg::*;

    localparam int TW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

    logic [7:0] ctrl_q, ctrl_d;
    logic       rx_s1_q, rx_s2_q, rx_prev_q;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       irq_q, irq_d;

    logic tx_en, rx_en, err_clear, tx_flush, rx_flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0] tx_head;

    tx_state_e     tx_state_q, tx_state_d;
    logic [TW-1:0] tx_timer_q, tx_timer_d;
    logic [BW-1:0] tx_bitcnt_q, tx_bitcnt_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_bit_end, tx_can_start, tx_pop, tx_busy;

    rx_state_e     rx_state_q, rx_state_d;
    logic [TW-1:0] rx_timer_q, rx_timer_d;
    logic [BW-1:0] rx_bitcnt_q, rx_bitcnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_bit_end, rx_fall, rx_push, rx_frame_evt, rx_busy, overrun_evt;

    assign tx_en     = ctrl_q[CTRL_TX_EN];
    assign rx_en     = ctrl_q[CTRL_RX_EN];
    assign err_clear = ctrl_q[CTRL_ERR_CLR];
    assign tx_flush  = ctrl_q[CTRL_TX_FLUSH];
    assign rx_flush  = ctrl_q[CTRL_RX_FLUSH];

    dsu_uart_sfifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (reg_txdata_we),
        .pop_i   (tx_pop),
        .flush_i (tx_flush),
        .data_i  (spr_dat_i),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    dsu_uart_sfifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (reg_rxdata_re),
        .flush_i (rx_flush),
        .data_i  (rx_shift_q),
        .head_o  (reg_rxdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    // Command bits [7:5] live for exactly one cycle after being written.
    always_comb begin
        ctrl_d = ctrl_q;
        ctrl_d[CTRL_RX_FLUSH:CTRL_ERR_CLR] = '0;
        if (reg_ctrl_we) begin
            ctrl_d = spr_dat_i;
        end
    end

    // A fresh error event outranks err_clear in the same cycle.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (err_clear) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
        if (rx_frame_evt) begin
            frame_err_d = 1'b1;
        end
    end

    assign irq_d = (ctrl_q[CTRL_IE_TX] & tx_empty & ~tx_busy)
                 | (ctrl_q[CTRL_IE_RX] & ~rx_empty)
                 | (ctrl_q[CTRL_IE_ERR] & (overrun_q | frame_err_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= CTRL_RESET;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            rx_s1_q     <= rxd;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
        end
    end

    assign reg_ctrl = ctrl_q;
    assign irq      = irq_q;

    always_comb begin
        reg_sta = '0;
        reg_sta[STA_TX_BUSY]    = tx_busy;
        reg_sta[STA_RX_BUSY]    = rx_busy;
        reg_sta[STA_TX_FULL]    = tx_full;
        reg_sta[STA_TX_EMPTY]   = tx_empty;
        reg_sta[STA_RX_FULL]    = rx_full;
        reg_sta[STA_RX_AVAIL]   = ~rx_empty;
        reg_sta[STA_RX_OVERRUN] = overrun_q;
        reg_sta[STA_FRAME_ERR]  = frame_err_q;
    end

    // ---------------- TX engine ----------------
    assign tx_bit_end   = (tx_timer_q == BIT_LAST);
    assign tx_can_start = tx_en & ~tx_empty & ~tx_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_timer_q  <= '0;
            tx_bitcnt_q <= '0;
            tx_shift_q  <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_timer_q  <= tx_timer_d;
            tx_bitcnt_q <= tx_bitcnt_d;
            tx_shift_q  <= tx_shift_d;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_timer_d  = tx_bit_end ? '0 : tx_timer_q + 1'b1;
        tx_bitcnt_d = tx_bitcnt_q;
        tx_shift_d  = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_timer_d = '0;
                if (tx_pop) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_head;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d  = TX_DATA;
                    tx_bitcnt_d = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d  = tx_shift_q >> 1;
                    tx_bitcnt_d = tx_bitcnt_q + 1'b1;
                    if (tx_bitcnt_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_pop) begin
                        tx_state_d = TX_START;
                        tx_shift_d = tx_head;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // txd is decoded from state so an asynchronous reset drives it high at once.
    always_comb begin
        tx_busy = (tx_state_q != TX_IDLE);
        tx_pop  = 1'b0;
        txd     = 1'b1;
        case (tx_state_q)
            TX_IDLE:  tx_pop = tx_can_start;
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift_q[0];
            TX_STOP:  tx_pop = tx_can_start & tx_bit_end;
            default:  txd = 1'b1;
        endcase
    end

    // ---------------- RX engine ----------------
    assign rx_bit_end = (rx_timer_q == BIT_LAST);
    assign rx_fall    = rx_prev_q & ~rx_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_timer_q  <= '0;
            rx_bitcnt_q <= '0;
            rx_shift_q  <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_timer_q  <= rx_timer_d;
            rx_bitcnt_q <= rx_bitcnt_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_timer_d  = rx_bit_end ? '0 : rx_timer_q + 1'b1;
        rx_bitcnt_d = rx_bitcnt_q;
        rx_shift_d  = rx_shift_q;
        if (!rx_en) begin
            rx_state_d = RX_IDLE;
            rx_timer_d = '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_timer_d = '0;
                    if (rx_fall) begin
                        rx_state_d = RX_START;
                    end
                end
                RX_START: begin
                    if (rx_timer_q == HALF_LAST) begin
                        rx_timer_d  = '0;
                        rx_bitcnt_d = '0;
                        rx_state_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_shift_d  = {rx_s2_q, rx_shift_q[7:1]};
                        rx_bitcnt_d = rx_bitcnt_q + 1'b1;
                        if (rx_bitcnt_q == LAST_BIT) begin
                            rx_state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    rx_timer_d = '0;
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_busy      = (rx_state_q != RX_IDLE);
        rx_push      = 1'b0;
        rx_frame_evt = 1'b0;
        if (rx_en && rx_state_q == RX_STOP && rx_bit_end) begin
            rx_push      = rx_s2_q;
            rx_frame_evt = ~rx_s2_q;
        end
        overrun_evt = rx_push & rx_full & ~reg_rxdata_re & ~rx_flush;
    end

endmodule

// File: tb/tb_dsu_uart_fifo.sv
// Randomised self-checking bench for dsu_uart_fifo at BAUD_DIV=8, FIFO_DEPTH=4,
// checked against a queue-based model of the serial link and FIFOs.
module tb_dsu_uart_fifo;

    localparam int BAUD  = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       txd;
    logic [7:0] spr_dat_i = '0;
    logic       reg_ctrl_we = 1'b0;
    logic       reg_txdata_we = 1'b0;
    logic       reg_rxdata_re = 1'b0;
    logic [7:0] reg_ctrl, reg_sta, reg_rxdata;
    logic [2:0] rx_level, tx_level;
    logic       irq;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] rxModel[$];
    logic [7:0] txModel[$];
    logic       ovrModel = 1'b0;
    logic       feModel  = 1'b0;

    dsu_uart_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .txd           (txd),
        .spr_dat_i     (spr_dat_i),
        .reg_ctrl_we   (reg_ctrl_we),
        .reg_txdata_we (reg_txdata_we),
        .reg_rxdata_re (reg_rxdata_re),
        .reg_ctrl      (reg_ctrl),
        .reg_sta       (reg_sta),
        .reg_rxdata    (reg_rxdata),
        .rx_level      (rx_level),
        .tx_level      (tx_level),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic ctrlWe, input logic txWe, input logic rxRe,
                                 input logic [7:0] data);
        reg_ctrl_we   = ctrlWe;
        reg_txdata_we = txWe;
        reg_rxdata_re = rxRe;
        spr_dat_i     = data;
        tick();
        reg_ctrl_we   = 1'b0;
        reg_txdata_we = 1'b0;
        reg_rxdata_re = 1'b0;
        spr_dat_i     = '0;
    endtask

    task automatic writeCtrl(input logic [7:0] v);
        applyStimulus(1'b1, 1'b0, 1'b0, v);
    endtask

    task automatic popRx();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        if (rxModel.size() > 0) void'(rxModel.pop_front());
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        rxd = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            tick(BAUD);
        end
        rxd = stopBit;
        tick(BAUD);
        rxd = 1'b1;
        tick(6);
        if (!stopBit) feModel = 1'b1;
        else if (rxModel.size() < DEPTH) rxModel.push_back(data);
        else ovrModel = 1'b1;
    endtask

    task automatic checkRxState(input string tag);
        logic [7:0] expHead;
        logic [7:0] expSta;
        expHead   = (rxModel.size() > 0) ? rxModel[0] : 8'h00;
        expSta    = 8'h08;
        expSta[4] = (rxModel.size() == DEPTH);
        expSta[5] = (rxModel.size() != 0);
        expSta[6] = ovrModel;
        expSta[7] = feModel;
        checkOutput({tag, "Level"}, 32'(rx_level), 32'(rxModel.size()));
        checkOutput({tag, "Head"}, 32'(reg_rxdata), 32'(expHead));
        checkOutput({tag, "Sta"}, 32'(reg_sta), 32'(expSta));
    endtask

    function automatic logic expTxBit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    task automatic receiveTxByte(output logic [7:0] data);
        int guard = 0;
        data = '0;
        while (txd === 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        checkOutput("txFrameStart", 32'(txd), 32'd0);
        tick(BAUD / 2);
        checkOutput("txStartMid", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(BAUD);
            data[i] = txd;
        end
        tick(BAUD);
        checkOutput("txStopBit", 32'(txd), 32'd1);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] frames[2];
        logic [7:0] pushed[5];
        int guard;
        int lows;

        // Reset state
        tick(3);
        rst = 1'b0;
        tick();
        checkOutput("rstCtrl", 32'(reg_ctrl), 32'h03);
        checkOutput("rstTxd", 32'(txd), 32'd1);
        checkOutput("rstIrq", 32'(irq), 32'd0);
        checkOutput("rstRxData", 32'(reg_rxdata), 32'h00);
        checkOutput("rstTxLevel", 32'(tx_level), 32'd0);
        checkOutput("rstRxLevel", 32'(rx_level), 32'd0);
        checkOutput("rstSta", 32'(reg_sta), 32'h08);

        // TX back-to-back frames with ie_tx
        writeCtrl(8'h07);
        tick(2);
        checkOutput("irqTxIdle", 32'(irq), 32'd1);
        frames[0] = 8'hA5;
        frames[1] = 8'h3C;
        applyStimulus(1'b0, 1'b1, 1'b0, frames[0]);
        applyStimulus(1'b0, 1'b1, 1'b0, frames[1]);
        guard = 0;
        while (txd === 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("txFirstStart", 32'(txd), 32'd0);
        checkOutput("txLevelQueued", 32'(tx_level), 32'd1);
        for (int k = 0; k < 160; k++) begin
            checkOutput("txBitStream", 32'(txd), 32'(expTxBit(frames[k / 80], (k % 80) / 8)));
            checkOutput("txBusyFrame", 32'(reg_sta[0]), 32'd1);
            if (k == 80) checkOutput("irqWhileBusy", 32'(irq), 32'd0);
            tick();
        end
        checkOutput("txBusyFell", 32'(reg_sta[0]), 32'd0);
        checkOutput("txIdleHigh", 32'(txd), 32'd1);
        checkOutput("irqNotYet", 32'(irq), 32'd0);
        tick();
        checkOutput("irqTxDone", 32'(irq), 32'd1);

        // TX FIFO full with tx_en=0: fifth push dropped
        writeCtrl(8'h02);
        for (int i = 0; i < 5; i++) begin
            pushed[i] = 8'($urandom);
            applyStimulus(1'b0, 1'b1, 1'b0, pushed[i]);
        end
        checkOutput("txFullLevel", 32'(tx_level), 32'd4);
        checkOutput("txFullFlag", 32'(reg_sta[2]), 32'd1);
        checkOutput("txNotEmpty", 32'(reg_sta[3]), 32'd0);
        checkOutput("txHeldIdle", 32'(txd), 32'd1);
        writeCtrl(8'h03);
        for (int i = 0; i < 4; i++) begin
            receiveTxByte(got);
            checkOutput("txFullByte", 32'(got), 32'(pushed[i]));
        end
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        checkOutput("txFifthAbsent", 32'(lows), 32'd0);
        checkOutput("txDrained", 32'(tx_level), 32'd0);

        // Randomised TX bursts
        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 4);
            writeCtrl(8'h02);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                txModel.push_back(b);
                applyStimulus(1'b0, 1'b1, 1'b0, b);
            end
            writeCtrl(8'h03);
            for (int i = 0; i < n; i++) begin
                receiveTxByte(got);
                checkOutput("txRandByte", 32'(got), 32'(txModel.pop_front()));
            end
        end
        tick(2 * BAUD);

        // RX directed byte
        sendFrame(8'h5A, 1'b1);
        checkRxState("rx5A");
        checkOutput("rx5AData", 32'(reg_rxdata), 32'h5A);
        popRx();
        checkRxState("rxPop");

        // Randomised RX traffic with pops
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) popRx();
            else sendFrame(8'($urandom), 1'b1);
            checkRxState("rxRand");
        end
        while (rxModel.size() > 0) popRx();
        writeCtrl(8'h23);
        checkOutput("ctrlCmdVisible", 32'(reg_ctrl), 32'h23);
        ovrModel = 1'b0;
        tick();
        checkOutput("ctrlSelfClear", 32'(reg_ctrl), 32'h03);
        checkRxState("rxCleared");

        // Overrun: five frames, no pops
        for (int i = 0; i < 5; i++) sendFrame(8'($urandom), 1'b1);
        checkRxState("rxOverrun");
        for (int i = 0; i < 4; i++) begin
            popRx();
            checkRxState("rxDrain");
        end

        // Start-bit glitch
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(3 * BAUD);
        checkRxState("rxGlitch");
        checkOutput("rxGlitchIdle", 32'(reg_sta[1]), 32'd0);

        // Framing error with ie_err, then err_clear
        writeCtrl(8'h33);
        ovrModel = 1'b0;
        tick();
        writeCtrl(8'h13);
        sendFrame(8'($urandom), 1'b0);
        checkRxState("rxFrameErr");
        checkOutput("irqFrameErr", 32'(irq), 32'd1);
        writeCtrl(8'h33);
        feModel = 1'b0;
        tick(2);
        checkOutput("frameErrCleared", 32'(reg_sta[7]), 32'd0);
        checkOutput("irqCleared", 32'(irq), 32'd0);

        // Reset in the middle of a TX data bit
        writeCtrl(8'h03);
        sendFrame(8'h77, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h11);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h22);
        tick(3 * BAUD);
        checkOutput("txDataLow", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rstAsyncTxd", 32'(txd), 32'd1);
        checkOutput("rstMidTxLevel", 32'(tx_level), 32'd0);
        checkOutput("rstMidRxLevel", 32'(rx_level), 32'd0);
        checkOutput("rstMidCtrl", 32'(reg_ctrl), 32'h03);
        checkOutput("rstMidIrq", 32'(irq), 32'd0);
        tick(2);
        rst = 1'b0;
        rxModel.delete();
        tick(2);
        checkOutput("postRstTxd", 32'(txd), 32'd1);
        checkOutput("postRstSta", 32'(reg_sta), 32'h08);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
